tff: RTL and testbench

Single-bit toggle flip-flop with complementary outputs. It is a leaf storage primitive: when the toggle input is high, the registered output inverts on every rising clock edge, and a synchronous active-high reset returns it to a known state. It is used directly in counters, dividers and flip-flop exercises, and is instantiated positionally in the port order listed below.

---
 rtl/tff.sv | 34 +++
 tb/tb_tff.sv | 118 +++++++++++
 2 files changed

// File: rtl/tff.sv
// Single-bit toggle flip-flop with complementary outputs and a synchronous,
// active-high reset to a parameterised initial value.
`timescale 1ns / 1ps

module tff #(
  parameter logic INIT = 1'b0
) (
  input  logic t,
  input  logic clk,
  input  logic rst,
  output logic q,
  output logic q_
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (t) q_d = ~q_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (rst) q_q <= INIT;
    else     q_q <= q_d;
  end

  // Both outputs come from the one register, so they can never disagree.
  assign q  = q_q;
  assign q_ = ~q_q;

endmodule

// File: tb/tb_tff.sv
// Directed bench for tff: a vector table for both INIT values plus hand-written
// sequences for mid-cycle input changes and divide-by-2 behaviour.
`timescale 1ns / 1ps

module tb_tff;

  typedef struct packed {
    logic rst;
    logic t;
    logic exp_q0;  // expected q of the INIT=0 instance after the edge
    logic exp_q1;  // expected q of the INIT=1 instance after the edge
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic t   = 1'b1;
  logic q0, q0_n, q1, q1_n;

  int n_checks = 0;
  int n_pass   = 0;

  vec_t vecs[$];

  always #10 clk = ~clk;

  tff #(.INIT(1'b0)) dut0 (.t(t), .clk(clk), .rst(rst), .q(q0), .q_(q0_n));
  tff #(.INIT(1'b1)) dut1 (.t(t), .clk(clk), .rst(rst), .q(q1), .q_(q1_n));

  task automatic check(input string name, input logic actual, input logic expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
  endtask

  task automatic add(input logic r, input logic tt, input logic e0, input logic e1);
    vecs.push_back('{rst: r, t: tt, exp_q0: e0, exp_q1: e1});
  endtask

  task automatic check_all(input string tag, input logic e0, input logic e1);
    check({tag, " q0"},  q0,   e0);
    check({tag, " q0_"}, q0_n, ~e0);
    check({tag, " q1"},  q1,   e1);
    check({tag, " q1_"}, q1_n, ~e1);
  endtask

  initial begin
    time rise_t[$];
    logic exp0;
    int   highs;

    // Reset held with t=1: no toggling, both instances sit at INIT.
    for (int i = 0; i < 5; i++) add(1, 1, 0, 1);
    // Released with t=0: hold.
    for (int i = 0; i < 5; i++) add(0, 0, 0, 1);
    // Toggling.
    add(0, 1, 1, 0);
    add(0, 1, 0, 1);
    add(0, 1, 1, 0);
    // Reset mid-toggle with t=1 wins, then toggling resumes from INIT.
    add(1, 1, 0, 1);
    add(0, 1, 1, 0);
    add(0, 1, 0, 1);
    // From reset: three toggles, then hold.
    add(1, 0, 0, 1);
    add(0, 1, 1, 0);
    add(0, 1, 0, 1);
    add(0, 1, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;
      t   = vecs[i].t;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].exp_q0, vecs[i].exp_q1);
    end

    // Mid-cycle rst/t pulses must not reach the outputs (state: q0=1, q1=0).
    @(negedge clk);
    rst = 1'b1;
    #2 check_all("async_rst", 1'b1, 1'b0);
    t = 1'b1;
    #2 check_all("async_t", 1'b1, 1'b0);
    rst = 1'b0;
    t   = 1'b0;
    @(posedge clk);
    #1 check_all("after_pulse", 1'b1, 1'b0);

    // Reset, then t held high: divide-by-2 with 50% duty and 40 ns period.
    @(negedge clk);
    rst = 1'b1;
    t   = 1'b1;
    @(posedge clk);
    #1 check_all("div_rst", 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    exp0  = 1'b0;
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      exp0 = ~exp0;
      check_all($sformatf("div%0d", i), exp0, ~exp0);
      if (q0 === 1'b1) begin
        highs++;
        rise_t.push_back($time);
      end
    end
    check("duty_high_count", (highs == 4), 1'b1);
    if (rise_t.size() >= 2) check("period_40ns", ((rise_t[1] - rise_t[0]) == 40), 1'b1);
    else check("period_rises_seen", 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
